// File: rtl/multiplicador_8bits_seq_pkg.sv
// multiplicador_8bits_seq_pkg: shared state encodings and iteration count for the shift-and-add multiplier.
package multiplicador_8bits_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    localparam int N_ITER = 8;
endpackage

// File: rtl/multiplicador_8bits_seq_somador.sv
// Somador8bitsMult: 8-bit ripple-carry adder with 9-bit sum (carry out in bit 8).
module Somador8bitsMult (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [8:0] s
);
    logic [8:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign s[8] = c[8];
endmodule

// File: rtl/multiplicador_8bits_seq.sv
// multiplicador_8bits_seq: sequential 8x8->16 unsigned shift-and-add multiplier with start/busy/done handshake.
// Define MULT_ZERO_BYPASS_EN to skip the iterations when either operand is zero.
module multiplicador_8bits_seq
    import multiplicador_8bits_seq_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           inicio,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] produto,
    output logic           ocupado,
    output logic           done
);
    state_t             state_q, state_d;
    logic [N-1:0]       acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, mcand_q, mcand_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N:0]         soma, sum9;

    Somador8bitsMult u_soma (
        .a   (acc_hi_q),
        .b   (mcand_q),
        .cin (1'b0),
        .s   (soma)
    );

    // Carry (sum9[N]) lands in acc_hi[N-1] on the shift.
    assign sum9 = acc_lo_q[0] ? soma : {1'b0, acc_hi_q};

    always_comb begin
        state_d  = state_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        count_d  = count_q;
        case (state_q)
            IDLE: if (inicio) begin
                acc_hi_d = '0;
                acc_lo_d = B;
                mcand_d  = A;
                count_d  = '0;
                state_d  = CALC;
`ifdef MULT_ZERO_BYPASS_EN
                if (A == '0 || B == '0) begin
                    acc_lo_d = '0;
                    state_d  = DONE;
                end
`endif
            end
            CALC: begin
                {acc_hi_d, acc_lo_d} = {sum9, acc_lo_q[N-1:1]};
                count_d = count_q + CNT_W'(1);
                state_d = (count_q == CNT_W'(N_ITER - 1)) ? DONE : CALC;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            count_q  <= count_d;
        end
    end

    assign produto = {acc_hi_q, acc_lo_q};
    assign ocupado = state_q != IDLE;
    assign done    = state_q == DONE;
endmodule
